// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   state_t    : controller state encoding (IDLE / RUN / DONE)
//   NIBBLE_W   : width of the shared adder slice
//   signed_ovf : two's-complement overflow decode from the three sign bits
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Overflow happens only when both addends share a sign and the sum's sign
  // differs from it. For subtraction the caller passes the inverted b sign.
  function automatic logic signed_ovf(input logic msb_a,
                                      input logic msb_b,
                                      input logic msb_r);
    return (msb_a == msb_b) && (msb_r != msb_a);
  endfunction

endpackage

// File: rtl/four_bits_adder_carry.sv
// 4-bit ripple adder slice built from a chain of full adders.
// Ports:
//   a, b   : 4-bit addends
//   ci     : carry in
//   result : 4-bit sum
//   cout   : carry out of the top bit
module four_bits_adder_carry (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] result,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign result[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1]    = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract performed one nibble per clock through a single shared
// 4-bit adder slice, LSB nibble first, with the inter-nibble carry held in a
// register.
// Parameters:
//   NIBBLES : number of 4-bit slices (2..8); operand width W = 4*NIBBLES
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request, accepted in IDLE or DONE
//   sub    : 0 = a+b, 1 = a-b (sampled with start)
//   a, b   : W-bit operands (sampled with start)
//   busy   : high while nibbles are processed
//   done   : one-cycle pulse, result/cout/ovf valid from this cycle
//   result : W-bit sum/difference, held until the next accepted start
//   cout   : final carry out (for subtract: 1 = no borrow)
//   ovf    : two's-complement overflow of the W-bit operation
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          sub,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   result,
  output logic                          cout,
  output logic                          ovf
);

  localparam int W      = NIBBLE_W * NIBBLES;
  localparam int IDX_W  = $clog2(NIBBLES);
  localparam int BASE_W = $clog2(W);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       op_a_q;
  logic [W-1:0]       op_b_q;
  logic [W-1:0]       result_q;
  logic               cout_q;
  logic               ovf_q;

  logic               accept;
  logic               last;
  logic [BASE_W-1:0]  base;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic               slice_cout;

  // A new request is only looked at once the previous one has finished.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last   = (idx_q == IDX_W'(NIBBLES - 1));

  // Bit offset of the current nibble: idx * 4, formed by concatenation so the
  // offset width matches the operand index width exactly.
  assign base    = {idx_q, 2'b00};
  assign slice_a = op_a_q[base +: NIBBLE_W];
  assign slice_b = op_b_q[base +: NIBBLE_W];

  four_bits_adder_carry u_slice (
    .a      (slice_a),
    .b      (slice_b),
    .ci     (carry_q),
    .result (slice_sum),
    .cout   (slice_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = last ? ST_DONE : ST_RUN;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: pure decodes of the registered state, no path from start.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // Operand latches: data only, loaded on acceptance. Subtraction is done as
  // a + ~b + 1, with the +1 entering as the initial carry.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_q <= a;
      op_b_q <= sub ? ~b : b;
    end
  end

  // Nibble walk: index, inter-nibble carry, result assembly and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      idx_q    <= '0;
      carry_q  <= sub;
      result_q <= '0;
    end else if (state_q == ST_RUN) begin
      result_q[base +: NIBBLE_W] <= slice_sum;
      carry_q                    <= slice_cout;
      if (last) begin
        cout_q <= slice_cout;
        // The top nibble is being written this cycle, so the result sign bit
        // comes straight from the slice output.
        ovf_q  <= signed_ovf(op_a_q[W-1], op_b_q[W-1], slice_sum[NIBBLE_W-1]);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that reuses a single 4-bit ripple adder slice to perform a wide add/subtract one nibble per clock. It latches operands on a start handshake and walks the nibbles LSB-first, carrying between them in a register. It reports result, carry-out and signed overflow with a one-cycle done pulse. It sits between the lab's operand registers/switch inputs and the seven-segment display path, replacing a wide combinational adder with one shared slice.

## Interface
- NIBBLES, 4, number of 4-bit slices processed; operand width W = 4*NIBBLES; legal range 2–8.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  W  first operand; sampled with start.
- b  input  W  second operand; sampled with start.
- busy  output  1  high while nibbles are being processed (RUN).
- done  output  1  one-cycle pulse; result/cout/ovf valid from this cycle.
- result  output  W  sum/difference, held until the next accepted start.
- cout  output  1  final carry out (for sub: 1 = no borrow).
- ovf  output  1  two's-complement overflow of the W-bit operation.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + start=1: latch opA=a, opB=(sub ? ~b : b), carry=sub, idx=0, clear result register; go RUN.
- IDLE + start=0 → IDLE; DONE + start=0 → IDLE.
- RUN, each cycle: adder slice gets opA[4idx+3:4idx], opB[4idx+3:4idx], carry; write sum into result[4idx+3:4idx]; carry ← slice carry-out; idx ← idx+1.
- RUN with idx = NIBBLES−1: after the write, cout ← slice carry-out, ovf computed, go DONE.
- ovf = (opA[W−1] == opB[W−1]) && (result[W−1] != opA[W−1]), using the inverted opB for sub.
- start while RUN: ignored, no effect on the operation in flight, no queuing.
- Operand inputs may change freely after the accepting edge; only latched copies are used.
- idx width = ceil(log2(NIBBLES)); it never wraps past NIBBLES−1.
- rst has priority over everything, including mid-RUN: state IDLE, idx 0, carry 0, operation abandoned, no done pulse.

## Timing
- Reset values: busy 0, done 0, result 0, cout 0, ovf 0.
- start accepted at edge E0 (cycle 0). busy is high in cycles 1..NIBBLES. done is high in cycle NIBBLES+1 only.
- Latency start → done = NIBBLES+1 cycles; 5 cycles for the default.
- busy = (state==RUN) and done = (state==DONE), both registered-state decodes with no combinational path from start.
- Back-to-back: start high during the done cycle is accepted. The next operation's busy rises the following cycle, for a throughput of one result per NIBBLES+1 cycles.
- result holds its previous value in IDLE. It is cleared on acceptance, so partial nibbles are visible during RUN and the result is valid only from done.

## Structure
- Shared include file: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NIBBLE_W=4 constant.
- One sub-module: a single instance of the team's 4-bit full-adder-chain slice (four_bits_adder_carry, ports a, b, ci, result, cout). It is not modified.
- Nibble select/insert uses indexed part-selects on idx. The controller FSM, idx counter and carry register live in this block.

## Test plan
- Add, NIBBLES=4: a=0x1234, b=0x0FCD, sub=0 → done at cycle 5, result=0x2201, cout=0, ovf=0; busy high exactly in cycles 1–4.
- Carry ripple across all nibbles: a=0xFFFF, b=0x0001 → result=0x0000, cout=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001 → result=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1 → result=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → result=0x7FFF, cout=1, ovf=1.
- start pulsed in cycle 2 of RUN with different operands → ignored; first result unchanged, exactly one done pulse.
- start held high through the done cycle with new operands 0x0001+0x0001 → second operation accepted, second done 5 cycles later, result=0x0002.
- rst asserted in cycle 3 of RUN → next cycle busy=0, done=0, result=0, cout=0, ovf=0; no done pulse follows. A fresh start afterwards completes normally.
